// File: rtl/reg_file_wb.sv
// 32 x 32-bit register file: two registered read ports, one write port, saturating write counter.
// Define WRITE_BYPASS_EN for write-before-read on same-edge collisions; the default is read-before-write.
module reg_file_wb (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    input  logic [4:0]  WriteRegister,
    input  logic [31:0] WriteData,
    input  logic        RegWrite,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [15:0] WriteCount
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] read_data1_q, read_data1_d;
    logic [31:0] read_data2_q, read_data2_d;
    logic [15:0] write_count_q, write_count_d;
    logic        write_en;

    // Writes to R0 are dropped; RegWrite gates first, so an unknown address with RegWrite=0 has no effect.
    assign write_en = RegWrite && (WriteRegister != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[WriteRegister] = WriteData;
        end
        regs_d[0] = '0;
    end

    always_comb begin
        read_data1_d = (ReadRegister1 == 5'd0) ? 32'd0 : regs_q[ReadRegister1];
        read_data2_d = (ReadRegister2 == 5'd0) ? 32'd0 : regs_q[ReadRegister2];
`ifdef WRITE_BYPASS_EN
        if (write_en && (ReadRegister1 == WriteRegister)) begin
            read_data1_d = WriteData;
        end
        if (write_en && (ReadRegister2 == WriteRegister)) begin
            read_data2_d = WriteData;
        end
`endif
    end

    always_comb begin
        write_count_d = write_count_q;
        if (write_en && (write_count_q != 16'hFFFF)) begin
            write_count_d = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            read_data1_q  <= '0;
            read_data2_q  <= '0;
            write_count_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            read_data1_q  <= read_data1_d;
            read_data2_q  <= read_data2_d;
            write_count_q <= write_count_d;
        end
    end

    assign ReadData1  = read_data1_q;
    assign ReadData2  = read_data2_q;
    assign WriteCount = write_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomised self-checking bench for reg_file_wb against a behavioural register-file model.
// The model follows WRITE_BYPASS_EN the same way the design is built.
module tb_reg_file_wb;

    logic        clk;
    logic        reset;
    logic [4:0]  read_register1;
    logic [4:0]  read_register2;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [15:0] write_count;

    int tests_run;
    int tests_failed;

    // Behavioural model: plain array of register contents plus an integer write count.
    logic [31:0] model_regs [32];
    int          model_count;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;

    reg_file_wb dut (
        .Clk           (clk),
        .Reset         (reset),
        .ReadRegister1 (read_register1),
        .ReadRegister2 (read_register2),
        .WriteRegister (write_register),
        .WriteData     (write_data),
        .RegWrite      (reg_write),
        .ReadData1     (read_data1),
        .ReadData2     (read_data2),
        .WriteCount    (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion before limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic rst, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] v;
        if (rst || ra == 5'd0) begin
            v = 32'd0;
        end else begin
            v = model_regs[ra];
`ifdef WRITE_BYPASS_EN
            if (we && wa == ra) v = wd;
`endif
        end
        return v;
    endfunction

    // Applies one cycle of inputs and advances the model; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        reset          = rst;
        reg_write      = we;
        write_register = wa;
        write_data     = wd;
        read_register1 = ra1;
        read_register2 = ra2;
        @(posedge clk);
        exp_rd1 = model_read(ra1, rst, we, wa, wd);
        exp_rd2 = model_read(ra2, rst, we, wa, wd);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_count = 0;
        end else if (we && wa != 5'd0) begin
            model_regs[wa] = wd;
            if (model_count < 65535) model_count = model_count + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd7);
        tests_run++;
        if (write_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %h want 0000", write_count);
        end
        for (int a = 0; a < 32; a++) begin
            step(1'b0, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
            tests_run++;
            if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset_read addr %0d: got %h/%h want 0/0", a, read_data1, read_data2);
            end
        end
        tests_run++;
        if (write_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_count_after_reads: got %h want 0000", write_count);
        end
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        tests_run++;
        if (read_data1 !== 32'hDEAD_BEEF || read_data2 !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL write_read_r5: got %h/%h want deadbeef/deadbeef", read_data1, read_data2);
        end
        tests_run++;
        if (write_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL write_read_count: got %h want 0001", write_count);
        end
    endtask

    task automatic test_r0();
        step(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        tests_run++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL r0_same_edge: got %h/%h want 0/0", read_data1, read_data2);
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tests_run++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL r0_read: got %h/%h want 0/0", read_data1, read_data2);
        end
        tests_run++;
        if (write_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL r0_count: got %h want 0001", write_count);
        end
    endtask

    task automatic test_collision();
        logic [31:0] want;
`ifdef WRITE_BYPASS_EN
        want = 32'hA5A5_A5A5;
`else
        want = 32'h0000_0001;
`endif
        step(1'b0, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9);
        tests_run++;
        if (read_data1 !== want || read_data2 !== want) begin
            tests_failed++;
            $display("FAIL collision_r9: got %h/%h want %h/%h", read_data1, read_data2, want, want);
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        tests_run++;
        if (read_data1 !== 32'hA5A5_A5A5 || read_data2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL collision_after: got %h/%h want a5a5a5a5/0", read_data1, read_data2);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b1, 1'b1, 5'd31, 32'h400, 5'd31, 5'd31);
        tests_run++;
        if (write_count !== 16'd0 || read_data1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_prio: got count %h rd1 %h want 0000/0", write_count, read_data1);
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd5);
        tests_run++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_prio_r31: got %h/%h want 0/0", read_data1, read_data2);
        end
        step(1'b0, 1'b1, 5'd31, 32'h400, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
        tests_run++;
        if (read_data1 !== 32'h400 || read_data2 !== 32'h400 || write_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL jal_r31: got %h/%h count %h want 400/400 count 0001", read_data1, read_data2, write_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tests_run++;
            if (read_data1 !== exp_rd1 || read_data2 !== exp_rd2 || write_count !== 16'(model_count)) begin
                tests_failed++;
                $display("FAIL random step %0d: got %h/%h count %h want %h/%h count %h", n,
                         read_data1, read_data2, write_count, exp_rd1, exp_rd2, 16'(model_count));
            end
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int n = 0; n < 65534; n++) begin
            step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0);
        end
        tests_run++;
        if (write_count !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL sat_fffe: got %h want fffe", write_count);
        end
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0);
            tests_run++;
            if (write_count !== 16'hFFFF) begin
                tests_failed++;
                $display("FAIL sat_write %0d: got %h want ffff", n, write_count);
            end
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd17);
        tests_run++;
        if (write_count !== 16'hFFFF || read_data1 !== exp_rd1 || read_data2 !== exp_rd2) begin
            tests_failed++;
            $display("FAIL sat_hold: got count %h rd %h/%h want ffff rd %h/%h",
                     write_count, read_data1, read_data2, exp_rd1, exp_rd2);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        model_count    = 0;
        exp_rd1        = '0;
        exp_rd2        = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        reset          = 1'b1;
        reg_write      = 1'b0;
        write_register = 5'd0;
        write_data     = 32'd0;
        read_register1 = 5'd0;
        read_register2 = 5'd0;

        test_reset();
        test_write_read();
        test_r0();
        test_collision();
        test_reset_priority();
        test_random();
        test_saturation();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
